// File: rtl/svga_timing_pkg.sv
// SVGA 800x600 timing constants, sync FSM state encoding and output bundle,
// shared between the sync generator and the pixel renderer.
package svga_timing_pkg;

    localparam int unsigned COUNT_W = 10;

    localparam int unsigned H_VISIBLE_DEFAULT   = 800;
    localparam int unsigned H_FRONT_DEFAULT     = 24;
    localparam int unsigned H_SYNC_DEFAULT      = 72;
    localparam int unsigned H_BACK_DEFAULT      = 128;
    localparam int unsigned V_VISIBLE_DEFAULT   = 600;
    localparam int unsigned V_FRONT_DEFAULT     = 1;
    localparam int unsigned V_SYNC_DEFAULT      = 2;
    localparam int unsigned V_BACK_DEFAULT      = 22;
    localparam int unsigned LOCK_CYCLES_DEFAULT = 16;

    localparam logic [0:0] WAIT_LOCK = 1'b0;
    localparam logic [0:0] RUN       = 1'b1;

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               video_active;
        logic               line_start;
        logic               frame_start;
        logic [COUNT_W-1:0] x;
        logic [COUNT_W-1:0] y;
    } sync_out_t;

    // Inclusive range test on 10-bit unsigned counter values.
    function automatic logic in_window(input logic [COUNT_W-1:0] value,
                                       input logic [COUNT_W-1:0] first,
                                       input logic [COUNT_W-1:0] last);
        return (value >= first) && (value <= last);
    endfunction

endpackage

// File: rtl/svga_lock_filter.sv
// PLL lock synchroniser plus qualification counter: qualified_c rises once the
// synchronised lock has been high for LOCK_CYCLES consecutive clocks.
module svga_lock_filter #(
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic running,
    output logic locked,
    output logic qualified_c
);

    localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic             meta;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            locked <= 1'b0;
        end else begin
            meta   <= pll_locked;
            locked <= meta;
        end
    end

    // Counter only qualifies while waiting; it is parked at zero in RUN so a lost
    // lock always restarts the full qualification window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (running || !locked) begin
            count <= '0;
        end else if (count != CNT_LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    assign qualified_c = locked && (count == CNT_LAST);

endmodule

// File: rtl/svga_sync_generator.sv
// SVGA sync generator: waits for a qualified PLL lock, then runs the h/v
// counters and emits registered sync, blanking and position outputs.
module svga_sync_generator
    import svga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = H_VISIBLE_DEFAULT,
    parameter int unsigned H_FRONT     = H_FRONT_DEFAULT,
    parameter int unsigned H_SYNC      = H_SYNC_DEFAULT,
    parameter int unsigned H_BACK      = H_BACK_DEFAULT,
    parameter int unsigned V_VISIBLE   = V_VISIBLE_DEFAULT,
    parameter int unsigned V_FRONT     = V_FRONT_DEFAULT,
    parameter int unsigned V_SYNC      = V_SYNC_DEFAULT,
    parameter int unsigned V_BACK      = V_BACK_DEFAULT,
    parameter logic        SYNC_POL    = 1'b1,
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
    input  logic               clk_36MHz,
    input  logic               reset,
    input  logic               pll_locked,
    output logic               hsync,
    output logic               vsync,
    output logic               video_active,
    output logic [COUNT_W-1:0] x,
    output logic [COUNT_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    localparam logic [COUNT_W-1:0] H_LAST      = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [COUNT_W-1:0] V_LAST      = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [COUNT_W-1:0] H_VIS_END   = COUNT_W'(H_VISIBLE);
    localparam logic [COUNT_W-1:0] V_VIS_END   = COUNT_W'(V_VISIBLE);
    localparam logic [COUNT_W-1:0] HSYNC_FIRST = COUNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [COUNT_W-1:0] HSYNC_LAST  = COUNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [COUNT_W-1:0] VSYNC_FIRST = COUNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [COUNT_W-1:0] VSYNC_LAST  = COUNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    localparam sync_out_t IDLE_OUT =
        sync_out_t'({~SYNC_POL, ~SYNC_POL, 3'b000, {(2 * COUNT_W){1'b0}}});

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [COUNT_W-1:0] h_count;
    logic [COUNT_W-1:0] h_next;
    logic [COUNT_W-1:0] v_count;
    logic [COUNT_W-1:0] v_next;
    sync_out_t          out_q;
    sync_out_t          out_next;
    logic               locked;
    logic               qualified_c;

    svga_lock_filter #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_filter (
        .clk         (clk_36MHz),
        .rst         (reset),
        .pll_locked  (pll_locked),
        .running     (state == RUN),
        .locked      (locked),
        .qualified_c (qualified_c)
    );

    always_ff @(posedge clk_36MHz or posedge reset) begin
        if (reset) begin
            state   <= WAIT_LOCK;
            h_count <= '0;
            v_count <= '0;
            out_q   <= IDLE_OUT;
        end else begin
            state   <= state_next;
            h_count <= h_next;
            v_count <= v_next;
            out_q   <= out_next;
        end
    end

    // Next state, counter advance and output decode of the current counters.
    always_comb begin
        state_next = state;
        h_next     = h_count;
        v_next     = v_count;
        out_next   = IDLE_OUT;

        case (state)
            WAIT_LOCK: begin
                h_next = '0;
                v_next = '0;
                if (qualified_c) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!locked) begin
                    state_next = WAIT_LOCK;
                    h_next     = '0;
                    v_next     = '0;
                end else if (h_count == H_LAST) begin
                    h_next = '0;
                    v_next = (v_count == V_LAST) ? '0 : v_count + COUNT_W'(1);
                end else begin
                    h_next = h_count + COUNT_W'(1);
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                h_next     = '0;
                v_next     = '0;
            end
        endcase

        if (state == RUN) begin
            out_next.video_active = (h_count < H_VIS_END) && (v_count < V_VIS_END);
            out_next.hsync        = in_window(h_count, HSYNC_FIRST, HSYNC_LAST) ? SYNC_POL : ~SYNC_POL;
            out_next.vsync        = in_window(v_count, VSYNC_FIRST, VSYNC_LAST) ? SYNC_POL : ~SYNC_POL;
            out_next.line_start   = (h_count == '0);
            out_next.frame_start  = (h_count == '0) && (v_count == '0);
            out_next.x            = h_count;
            out_next.y            = v_count;
        end
    end

    assign hsync        = out_q.hsync;
    assign vsync        = out_q.vsync;
    assign video_active = out_q.video_active;
    assign line_start   = out_q.line_start;
    assign frame_start  = out_q.frame_start;
    assign x            = out_q.x;
    assign y            = out_q.y;

endmodule
